// File: rtl/xprog_loader.sv
// xprog_loader: boot-time program loader placed in front of the program RAM.
//
// Takes a byte stream and builds instruction words from it. The stream is a
// 16-bit big-endian word count N, then N words of DATA_W/8 bytes each, with
// the MSB byte first. Each finished word is written to program RAM in a
// single-cycle WRITE state. The controller is held in reset (cpu_hold=1)
// until the whole image has been loaded.
//
// Optional feature, enabled by defining XPROG_LOADER_CKSUM_EN:
//   After the last word, one more byte is taken as a checksum. It must equal
//   the 8-bit sum of every earlier byte in the session. A match goes to DONE;
//   a mismatch goes to ERR. Words already written stay in RAM.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   start                one-cycle pulse; opens a session from IDLE/DONE/ERR
//   in_valid, in_data    upstream byte stream
//   in_ready             byte is consumed when in_valid & in_ready
//   prog_sel, prog_we    program RAM write strobes (high only in WRITE)
//   prog_addr, prog_data program RAM word address / word (held between writes)
//   cpu_hold             high while the controller must stay in reset
//   busy, done, err      session status (done/err hold until the next start)
//   word_cnt             words written in the current or last session
module xprog_loader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              prog_sel,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int BYTES = DATA_W / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WCW   = ADDR_W + 1;
  // Number of words that fit between BASE_ADDR and the top of the RAM.
  localparam longint unsigned MAX_WORDS = (64'd1 << ADDR_W) - 64'(BASE_ADDR);

`ifdef XPROG_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR, S_CKSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;
`endif

  state_t              state_reg, state_next;
  logic [15:0]         len_reg;
  logic [BCW-1:0]      byte_cnt_reg;
  logic [DATA_W-1:0]   shift_reg;
  logic [WCW-1:0]      word_cnt_reg;
  logic [ADDR_W-1:0]   prog_addr_reg;
  logic [DATA_W-1:0]   prog_data_reg;
`ifdef XPROG_LOADER_CKSUM_EN
  logic [7:0]          sum_reg;
`endif

  logic                accept;
  logic                last_byte;
  logic                last_word;
  logic                start_session;
  logic [15:0]         len_full;
  logic [DATA_W-1:0]   shift_next;
  logic [WCW-1:0]      word_inc;

  assign accept        = in_valid & in_ready;
  assign last_byte     = (byte_cnt_reg == BCW'(BYTES - 1));
  assign len_full      = {len_reg[15:8], in_data};
  assign shift_next    = (shift_reg << 8) | DATA_W'(in_data);
  assign word_inc      = word_cnt_reg + WCW'(1);
  assign last_word     = (64'(word_inc) == 64'(len_reg));
  assign start_session = start && (state_reg == S_IDLE || state_reg == S_DONE ||
                                   state_reg == S_ERR);

  assign prog_addr = prog_addr_reg;
  assign prog_data = prog_data_reg;
  assign word_cnt  = word_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    prog_sel   = 1'b0;
    prog_we    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    cpu_hold   = 1'b1;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (len_full == 16'd0)                 state_next = S_DONE;
          else if (64'(len_full) > MAX_WORDS)    state_next = S_ERR;
          else                                   state_next = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid && last_byte) state_next = S_WRITE;
      end
      S_WRITE: begin
        prog_sel = 1'b1;
        prog_we  = 1'b1;
        if (last_word) begin
`ifdef XPROG_LOADER_CKSUM_EN
          state_next = S_CKSUM;
`else
          state_next = S_DONE;
`endif
        end else begin
          state_next = S_DATA;
        end
      end
`ifdef XPROG_LOADER_CKSUM_EN
      S_CKSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (in_data == sum_reg) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        busy     = 1'b0;
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_next = S_LEN_HI;
      end
      S_ERR: begin
        busy = 1'b0;
        err  = 1'b1;
        if (start) state_next = S_LEN_HI;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_reg       <= '0;
      byte_cnt_reg  <= '0;
      shift_reg     <= '0;
      word_cnt_reg  <= '0;
      prog_addr_reg <= '0;
      prog_data_reg <= '0;
`ifdef XPROG_LOADER_CKSUM_EN
      sum_reg       <= '0;
`endif
    end else begin
      if (start_session) begin
        len_reg      <= '0;
        byte_cnt_reg <= '0;
        shift_reg    <= '0;
        word_cnt_reg <= '0;
`ifdef XPROG_LOADER_CKSUM_EN
        sum_reg      <= '0;
`endif
      end
      if (accept) begin
`ifdef XPROG_LOADER_CKSUM_EN
        sum_reg <= sum_reg + in_data;
`endif
        case (state_reg)
          S_LEN_HI: len_reg[15:8] <= in_data;
          S_LEN_LO: len_reg[7:0]  <= in_data;
          S_DATA: begin
            shift_reg    <= shift_next;
            byte_cnt_reg <= last_byte ? '0 : byte_cnt_reg + BCW'(1);
            // Latch address and word now so they are stable for the whole
            // WRITE cycle and stay put afterwards.
            if (last_byte) begin
              prog_data_reg <= shift_next;
              prog_addr_reg <= ADDR_W'(BASE_ADDR) + word_cnt_reg[ADDR_W-1:0];
            end
          end
          default: ;
        endcase
      end
      if (state_reg == S_WRITE) word_cnt_reg <= word_inc;
    end
  end

endmodule

// File: doc/xprog_loader.md
Name: xprog_loader

Overview:
- Boot-time program loader that sits directly upstream of the program memory.
- Accepts a byte stream (e.g. from a UART/PS2 receiver bridge), assembles instruction words, and writes them into program RAM through its data write interface (sel/we/addr/data).
- Holds the controller in reset until loading completes, then releases it so fetch starts from the loaded image.

Parameters:
ADDR_W, 10, program RAM word-address width; RAM depth = 2**ADDR_W.
DATA_W, 32, instruction/data word width; must be a multiple of 8.
BASE_ADDR, 0, first RAM word address written; must be < 2**ADDR_W.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-low reset (0 = reset).
start  input  1  one-cycle pulse; begins a load session; ignored unless state is IDLE, DONE or ERR.
in_valid  input  1  byte valid from upstream.
in_data  input  8  byte payload.
in_ready  output  1  byte accepted when in_valid & in_ready are both high on the same edge.
prog_sel  output  1  program RAM data-interface select.
prog_we  output  1  program RAM write enable.
prog_addr  output  ADDR_W  program RAM word address.
prog_data  output  DATA_W  assembled word.
cpu_hold  output  1  high = controller held in reset.
busy  output  1  session in progress.
done  output  1  sticky: last session completed OK.
err  output  1  sticky: last session aborted.
word_cnt  output  ADDR_W+1  words written in the current or last session.

Behaviour:
- Reset (rst=0 at an edge): state IDLE; in_ready=0, prog_sel=0, prog_we=0, prog_addr=0, prog_data=0, cpu_hold=1, busy=0, done=0, err=0, word_cnt=0; byte counter and length register cleared.
- Reset mid-session aborts immediately; a RAM write in flight that cycle is dropped.
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words of DATA_W/8 bytes each, MSB byte first.
- IDLE:
  - in_ready=0.
  - On start: go to LEN_HI; busy=1, cpu_hold=1, done=0, err=0, word_cnt=0.
- LEN_HI / LEN_LO:
  - in_ready=1; one byte accepted per handshake.
  - After LEN_LO:
    - N=0: go to DONE.
    - N > 2**ADDR_W - BASE_ADDR: go to ERR, with no write.
    - Otherwise go to DATA.
- DATA:
  - in_ready=1; shift register holds bytes, MSB first.
  - Byte counter wraps from DATA_W/8-1 to 0.
  - On the last byte of a word: go to WRITE.
- WRITE (exactly one cycle):
  - in_ready=0; prog_sel=prog_we=1.
  - prog_addr = BASE_ADDR + word_cnt (ADDR_W bits, never wraps, guaranteed by the length check).
  - prog_data = assembled word.
  - Next edge: word_cnt+1; if word_cnt+1 == N, go to DONE (or CKSUM if enabled), else go to DATA.
- prog_sel and prog_we are 0 in every state except WRITE; prog_addr and prog_data hold their last value outside WRITE.
- DONE: busy=0, done=1, cpu_hold=0 from the cycle after entry; in_ready=0.
- ERR: busy=0, err=1, cpu_hold stays 1; in_ready=0.
- start in DONE or ERR begins a new session: cpu_hold returns to 1 the same edge.
- in_valid low stalls any receive state indefinitely; no timeout.
- Bytes presented while in_ready=0 are not consumed.
- Latency: last byte accepted at edge k → write asserted in cycle k+1 → done=1 at edge k+2 when N is reached.

Optional Feature:
- Macro XPROG_LOADER_CKSUM_EN.
- Defined: after the last word, state CKSUM accepts one extra byte.
  - Required value: the 8-bit modular sum of all preceding session bytes, LEN bytes included.
  - Match → DONE; mismatch → ERR.
  - Words already written stay in RAM; cpu_hold stays 1 on ERR.
- Undefined: no CKSUM state; DONE follows the last WRITE directly; no extra byte consumed.

Test Plan:
- Reset with rst=0 for 3 cycles → cpu_hold=1, in_ready=0, prog_we=0, done=0, err=0, word_cnt=0.
- start, stream 00 02 DE AD BE EF 01 02 03 04, in_valid always high, BASE_ADDR=0 → writes (0,0xDEADBEEF), (1,0x01020304), each prog_we for one cycle; done=1, cpu_hold=0, word_cnt=2.
- Same stream with in_valid toggling 1/0 every cycle → identical writes and final state; no byte lost or duplicated.
- Header 04 01 (N=1025 > 1024) → err=1, cpu_hold=1, prog_we never asserted; header 00 00 → done=1, no writes.
- rst=0 for one cycle after the 5th data byte, then start and a full 1-word stream 00 01 11 22 33 44 → only write (0,0x11223344); no stale bytes.
- CKSUM_EN: stream 00 01 11 22 33 44 AB (sum 0xAB) → done=1; trailing byte AC → err=1, cpu_hold=1, RAM word 0 = 0x11223344.
